// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the MEM-stage data-memory access unit: writeback mux select,
// store width select and the access FSM state encoding.
package dmem_access_unit_pkg;

    typedef enum logic [3:0] {
        alu_out, br_en, u_imm, lw, pc_plus4, lb, lbu, lh, lhu
    } regfilemux_sel_t;

    typedef enum logic [1:0] {sb, sh, sw} store_sel_t;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} dmem_state_t;

    // Loads accept funct3 000/001/010/100/101; stores only 000/001/010.
    function automatic logic funct3_legal(input logic [2:0] f3, input logic is_load);
        case (f3)
            3'b000, 3'b001, 3'b010: return 1'b1;
            3'b100, 3'b101:         return is_load;
            default:                return 1'b0;
        endcase
    endfunction

    function automatic regfilemux_sel_t load_sel_of(input logic [2:0] f3);
        case (f3)
            3'b000:  return lb;
            3'b001:  return lh;
            3'b100:  return lbu;
            3'b101:  return lhu;
            default: return lw;
        endcase
    endfunction

endpackage

// File: rtl/dmem_access_unit_store_formatter.sv
// Combinational store lane formatting: byte enables, replicated write data and
// natural-alignment check for the access width.
module dmem_access_unit_store_formatter
    import dmem_access_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  store_sel_t  store_sel,
    input  logic [31:0] rs2,
    output logic [3:0]  mbe,
    output logic [31:0] wdata,
    output logic        aligned
);

    always_comb begin
        mbe     = 4'b0000;
        wdata   = 32'h0;
        aligned = 1'b1;
        case (store_sel)
            sb: begin
                mbe   = 4'b0001 << addr_lo;
                wdata = {4{rs2[7:0]}};
            end
            sh: begin
                mbe     = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{rs2[15:0]}};
                aligned = ~addr_lo[0];
            end
            sw: begin
                mbe     = 4'b1111;
                wdata   = rs2;
                aligned = (addr_lo == 2'b00);
            end
            default: aligned = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// MEM-stage data-memory initiator: single-outstanding read/write handshake to the
// data cache, pipeline stall until response, raw load word plus extender select.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    input  logic            req_load,
    input  logic            req_store,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_rs2,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [31:0]     dmem_address,
    output logic [3:0]      dmem_mbe,
    output logic [31:0]     dmem_wdata,
    input  logic [31:0]     dmem_rdata,
    input  logic            dmem_resp,
    output logic            stall,
    output logic            load_valid,
    output logic [31:0]     load_word,
    output regfilemux_sel_t load_sel,
    output logic [1:0]      load_offset,
    output logic            misalign,
    output logic            timeout_err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    dmem_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            is_load_q, is_load_d;
    logic [31:0]     addr_q, addr_d;
    logic [3:0]      mbe_q, mbe_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     load_word_q, load_word_d;
    regfilemux_sel_t load_sel_q, load_sel_d;
    logic [1:0]      offset_q, offset_d;
    logic            misalign_q, misalign_d;
    logic            timeout_q, timeout_d;

    store_sel_t      store_sel;
    logic [3:0]      fmt_mbe;
    logic [31:0]     fmt_wdata;
    logic            fmt_aligned;
    logic            mem_op, ok, accept, reject, timeout_hit;

    always_comb begin
        store_sel = sb;
        case (req_funct3[1:0])
            2'b01:   store_sel = sh;
            2'b10:   store_sel = sw;
            default: store_sel = sb;
        endcase
    end

    dmem_access_unit_store_formatter u_fmt (
        .addr_lo   (req_addr[1:0]),
        .store_sel (store_sel),
        .rs2       (req_rs2),
        .mbe       (fmt_mbe),
        .wdata     (fmt_wdata),
        .aligned   (fmt_aligned)
    );

    assign mem_op      = req_valid & (req_load | req_store);
    assign ok          = funct3_legal(req_funct3, req_load) & fmt_aligned;
    assign accept      = (state_q == IDLE) & mem_op & ok;
    assign reject      = (state_q == IDLE) & mem_op & ~ok;
    assign timeout_hit = (state_q == ACCESS) & ~dmem_resp & (cnt_q == CNT_LAST);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_load_d   = is_load_q;
        addr_d      = addr_q;
        mbe_d       = mbe_q;
        wdata_d     = wdata_q;
        load_word_d = load_word_q;
        load_sel_d  = load_sel_q;
        offset_d    = offset_q;
        misalign_d  = reject;
        timeout_d   = timeout_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d   = ACCESS;
                    cnt_d     = '0;
                    is_load_d = req_load;
                    addr_d    = {req_addr[31:2], 2'b00};
                    mbe_d     = req_load ? 4'b0000 : fmt_mbe;
                    wdata_d   = req_load ? 32'h0 : fmt_wdata;
                    if (req_load) begin
                        load_sel_d = load_sel_of(req_funct3);
                        offset_d   = req_addr[1:0];
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_resp) begin
                    state_d = DONE;
                    if (is_load_q) load_word_d = dmem_rdata;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_load_q   <= 1'b0;
            addr_q      <= 32'h0;
            mbe_q       <= 4'b0000;
            wdata_q     <= 32'h0;
            load_word_q <= 32'h0;
            load_sel_q  <= lw;
            offset_q    <= 2'b00;
            misalign_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_load_q   <= is_load_d;
            addr_q      <= addr_d;
            mbe_q       <= mbe_d;
            wdata_q     <= wdata_d;
            load_word_q <= load_word_d;
            load_sel_q  <= load_sel_d;
            offset_q    <= offset_d;
            misalign_q  <= misalign_d;
            timeout_q   <= timeout_d;
        end
    end

    // Stall releases in the timeout cycle so the stuck instruction leaves EX/MEM.
    assign stall        = accept | ((state_q == ACCESS) & ~timeout_hit);
    assign dmem_read    = (state_q == ACCESS) & is_load_q;
    assign dmem_write   = (state_q == ACCESS) & ~is_load_q;
    assign dmem_address = addr_q;
    assign dmem_mbe     = mbe_q;
    assign dmem_wdata   = wdata_q;
    assign load_valid   = (state_q == DONE) & is_load_q;
    assign load_word    = load_word_q;
    assign load_sel     = load_sel_q;
    assign load_offset  = offset_q;
    assign misalign     = misalign_q;
    assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: stores, loads, misalignment, timeout and
// reset mid-access, with hand-computed expectations.
module tb_dmem_access_unit;
    import dmem_access_unit_pkg::*;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_load, req_store;
    logic [2:0]      req_funct3;
    logic [31:0]     req_addr, req_rs2;
    logic            dmem_read, dmem_write;
    logic [31:0]     dmem_address;
    logic [3:0]      dmem_mbe;
    logic [31:0]     dmem_wdata;
    logic [31:0]     dmem_rdata;
    logic            dmem_resp;
    logic            stall, load_valid;
    logic [31:0]     load_word;
    regfilemux_sel_t load_sel;
    logic [1:0]      load_offset;
    logic            misalign, timeout_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_access_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_load     (req_load),
        .req_store    (req_store),
        .req_funct3   (req_funct3),
        .req_addr     (req_addr),
        .req_rs2      (req_rs2),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_mbe     (dmem_mbe),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .stall        (stall),
        .load_valid   (load_valid),
        .load_word    (load_word),
        .load_sel     (load_sel),
        .load_offset  (load_offset),
        .misalign     (misalign),
        .timeout_err  (timeout_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_samp();
        @(negedge clk);
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2);
        req_valid  = 1'b1;
        req_load   = ld;
        req_store  = ~ld;
        req_funct3 = f3;
        req_addr   = addr;
        req_rs2    = rs2;
    endtask

    task automatic idle_req();
        req_valid = 1'b0;
        req_load  = 1'b0;
        req_store = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        idle_req();
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_rs2    = 32'h0;
        dmem_rdata = 32'h0;
        dmem_resp  = 1'b0;
        repeat (2) to_samp();
        chk("rst_stall", {31'h0, stall}, 32'd0);
        chk("rst_rw", {30'h0, dmem_read, dmem_write}, 32'd0);
        chk("rst_addr", dmem_address, 32'h0);
        chk("rst_mbe_wdata", {28'h0, dmem_mbe} | dmem_wdata, 32'h0);
        chk("rst_flags", {29'h0, load_valid, misalign, timeout_err}, 32'd0);
        chk("rst_load_sel", {28'h0, load_sel}, {28'h0, lw});
        chk("rst_offset", {30'h0, load_offset}, 32'd0);
        to_drive();
        rst_n = 1'b1;

        // sw 0x100, response in the third ACCESS cycle
        to_drive();
        issue(1'b0, 3'b010, 32'h100, 32'hDEADBEEF);
        to_samp();
        chk("sw_accept_stall", {31'h0, stall}, 32'd1);
        chk("sw_accept_nowrite", {31'h0, dmem_write}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            to_drive();
            dmem_resp = (i == 2);
            to_samp();
            chk("sw_write", {30'h0, dmem_read, dmem_write}, 32'd1);
            chk("sw_stall", {31'h0, stall}, 32'd1);
        end
        chk("sw_addr", dmem_address, 32'h100);
        chk("sw_mbe", {28'h0, dmem_mbe}, 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        to_drive();
        dmem_resp = 1'b0;
        to_samp();
        chk("sw_done_write", {31'h0, dmem_write}, 32'd0);
        chk("sw_done_stall", {31'h0, stall}, 32'd0);
        chk("sw_done_lv", {31'h0, load_valid}, 32'd0);
        to_drive();
        idle_req();

        // sb 0x103
        to_drive();
        issue(1'b0, 3'b000, 32'h103, 32'h000000A5);
        to_drive();
        dmem_resp = 1'b1;
        to_samp();
        chk("sb_write", {31'h0, dmem_write}, 32'd1);
        chk("sb_mbe", {28'h0, dmem_mbe}, 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5A5A5);
        chk("sb_addr", dmem_address, 32'h100);
        to_drive();
        dmem_resp = 1'b0;
        to_drive();
        idle_req();

        // sh 0x0A2: upper half
        to_drive();
        issue(1'b0, 3'b001, 32'h0A2, 32'h1234BEEF);
        to_drive();
        dmem_resp = 1'b1;
        to_samp();
        chk("sh_mbe", {28'h0, dmem_mbe}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hBEEFBEEF);
        to_drive();
        dmem_resp = 1'b0;
        to_drive();
        idle_req();

        // lhu 0x202
        to_drive();
        issue(1'b1, 3'b101, 32'h202, 32'h0);
        to_drive();
        dmem_rdata = 32'h8001FFFF;
        dmem_resp  = 1'b1;
        to_samp();
        chk("lhu_read", {30'h0, dmem_read, dmem_write}, 32'd2);
        chk("lhu_mbe", {28'h0, dmem_mbe}, 32'h0);
        chk("lhu_addr", dmem_address, 32'h200);
        to_drive();
        dmem_resp  = 1'b0;
        dmem_rdata = 32'h0;
        to_samp();
        chk("lhu_lv", {31'h0, load_valid}, 32'd1);
        chk("lhu_word", load_word, 32'h8001FFFF);
        chk("lhu_sel", {28'h0, load_sel}, {28'h0, lhu});
        chk("lhu_offset", {30'h0, load_offset}, 32'd2);
        chk("lhu_done_stall", {31'h0, stall}, 32'd0);
        to_drive();
        idle_req();
        to_samp();
        chk("lhu_lv_pulse", {31'h0, load_valid}, 32'd0);

        // lw 0x101: misaligned
        to_drive();
        issue(1'b1, 3'b010, 32'h101, 32'h0);
        to_samp();
        chk("mis_stall", {31'h0, stall}, 32'd0);
        chk("mis_rw0", {30'h0, dmem_read, dmem_write}, 32'd0);
        to_drive();
        idle_req();
        to_samp();
        chk("mis_pulse", {31'h0, misalign}, 32'd1);
        chk("mis_rw1", {30'h0, dmem_read, dmem_write}, 32'd0);
        to_drive();
        to_samp();
        chk("mis_pulse_end", {31'h0, misalign}, 32'd0);

        // store with load-only funct3 is illegal
        to_drive();
        issue(1'b0, 3'b100, 32'h40, 32'h0);
        to_drive();
        idle_req();
        to_samp();
        chk("illegal_f3", {30'h0, misalign, dmem_write}, 32'd2);

        // lw 0x300 with no response: timeout after 8 ACCESS cycles
        to_drive();
        issue(1'b1, 3'b010, 32'h300, 32'h0);
        for (int i = 0; i < 8; i++) begin
            to_drive();
            to_samp();
            chk("to_read", {31'h0, dmem_read}, 32'd1);
            chk("to_stall", {31'h0, stall}, (i < 7) ? 32'd1 : 32'd0);
            chk("to_err_early", {31'h0, timeout_err}, 32'd0);
        end
        to_drive();
        idle_req();
        to_samp();
        chk("to_err", {31'h0, timeout_err}, 32'd1);
        chk("to_idle", {30'h0, dmem_read, stall}, 32'd0);
        to_drive();
        dmem_rdata = 32'h55AA55AA;
        dmem_resp  = 1'b1;
        to_drive();
        dmem_resp = 1'b0;
        to_samp();
        chk("to_late_lv", {31'h0, load_valid}, 32'd0);
        chk("to_sticky", {31'h0, timeout_err}, 32'd1);

        // lb 0x400 with reset on the second ACCESS cycle
        to_drive();
        issue(1'b1, 3'b000, 32'h400, 32'h0);
        to_drive();
        to_samp();
        chk("rs_read1", {31'h0, dmem_read}, 32'd1);
        to_drive();
        rst_n = 1'b0;
        idle_req();
        #1;
        chk("rs_read_drop", {30'h0, dmem_read, stall}, 32'd0);
        chk("rs_to_clear", {31'h0, timeout_err}, 32'd0);
        to_drive();
        rst_n = 1'b1;
        to_drive();
        dmem_rdata = 32'h12345678;
        dmem_resp  = 1'b1;
        to_drive();
        dmem_resp = 1'b0;
        to_samp();
        chk("rs_late_lv", {31'h0, load_valid}, 32'd0);
        chk("rs_late_word", load_word, 32'h0);
        chk("rs_idle", {30'h0, dmem_read, stall}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
